// File: rtl/riscv_decode_stage_if.sv
// Fetch-side and execute-side handshake bus of riscv_decode_stage. Suffixes name the direction
// as seen by the decode stage; the decode stage takes the slave modport.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

interface riscv_decode_stage_if #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned PC_WIDTH = 32
);
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [31:0]              in_instr_i;
    logic [PC_WIDTH-1:0]      in_pc_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [PC_WIDTH-1:0]      out_pc_o;
    logic [1:0]               ex_op_a_sel_o;
    logic [2:0]               ex_op_b_sel_o;
    logic [`ALU_OP_WIDTH-1:0] alu_op_o;
    logic                     mem_req_o;
    logic                     mem_we_o;
    logic [2:0]               mem_size_o;
    logic                     gpr_we_a_o;
    logic                     wb_src_sel_o;
    logic                     branch_o;
    logic                     jal_o;
    logic                     jalr_o;
    logic                     illegal_instr_o;
    logic [31:0]              imm_o;
    logic [4:0]               rd_o;
    logic [$clog2(DEPTH):0]   level_o;

    modport master (
        output in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
               mem_req_o, mem_we_o, mem_size_o, gpr_we_a_o, wb_src_sel_o, branch_o, jal_o,
               jalr_o, illegal_instr_o, imm_o, rd_o, level_o
    );

    modport slave (
        input  in_valid_i, in_instr_i, in_pc_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
               mem_req_o, mem_we_o, mem_size_o, gpr_we_a_o, wb_src_sel_o, branch_o, jal_o,
               jalr_o, illegal_instr_o, imm_o, rd_o, level_o
    );
endinterface

// File: rtl/riscv_decode_stage.sv
// Registered RV32I decode stage: DEPTH-entry fetch queue feeding a decoded output register.
// Define DECODE_RV32M_EN to additionally decode the RV32M multiply/divide group.
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 5
`endif

module riscv_decode_stage #(
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned PC_WIDTH = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    riscv_decode_stage_if.slave bus
);
    localparam int unsigned   PW = $clog2(DEPTH);
    localparam int unsigned   LW = $clog2(DEPTH) + 1;
    localparam int unsigned   AW = `ALU_OP_WIDTH;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    localparam logic [1:0] OP_A_RS1     = 2'd0;
    localparam logic [1:0] OP_A_CURR_PC = 2'd1;
    localparam logic [1:0] OP_A_ZERO    = 2'd2;

    localparam logic [2:0] OP_B_RS2   = 3'd0;
    localparam logic [2:0] OP_B_IMM_I = 3'd1;
    localparam logic [2:0] OP_B_IMM_U = 3'd2;
    localparam logic [2:0] OP_B_IMM_S = 3'd3;
    localparam logic [2:0] OP_B_INCR  = 3'd4;

    localparam logic [AW-1:0] ALU_ADD    = AW'(0);
    localparam logic [AW-1:0] ALU_SUB    = AW'(1);
    localparam logic [AW-1:0] ALU_XOR    = AW'(2);
    localparam logic [AW-1:0] ALU_OR     = AW'(3);
    localparam logic [AW-1:0] ALU_AND    = AW'(4);
    localparam logic [AW-1:0] ALU_SLL    = AW'(5);
    localparam logic [AW-1:0] ALU_SRL    = AW'(6);
    localparam logic [AW-1:0] ALU_SRA    = AW'(7);
    localparam logic [AW-1:0] ALU_SLT    = AW'(8);
    localparam logic [AW-1:0] ALU_SLTU   = AW'(9);
    localparam logic [AW-1:0] ALU_EQ     = AW'(10);
    localparam logic [AW-1:0] ALU_NE     = AW'(11);
    localparam logic [AW-1:0] ALU_LT     = AW'(12);
    localparam logic [AW-1:0] ALU_GE     = AW'(13);
    localparam logic [AW-1:0] ALU_LTU    = AW'(14);
    localparam logic [AW-1:0] ALU_GEU    = AW'(15);
`ifdef DECODE_RV32M_EN
    localparam logic [AW-1:0] ALU_MUL    = AW'(16);
    localparam logic [AW-1:0] ALU_MULH   = AW'(17);
    localparam logic [AW-1:0] ALU_MULHSU = AW'(18);
    localparam logic [AW-1:0] ALU_MULHU  = AW'(19);
    localparam logic [AW-1:0] ALU_DIV    = AW'(20);
    localparam logic [AW-1:0] ALU_DIVU   = AW'(21);
    localparam logic [AW-1:0] ALU_REM    = AW'(22);
    localparam logic [AW-1:0] ALU_REMU   = AW'(23);
`endif

    localparam logic [6:0] OPC_LOAD     = 7'h03;
    localparam logic [6:0] OPC_MISC_MEM = 7'h0F;
    localparam logic [6:0] OPC_OP_IMM   = 7'h13;
    localparam logic [6:0] OPC_AUIPC    = 7'h17;
    localparam logic [6:0] OPC_STORE    = 7'h23;
    localparam logic [6:0] OPC_OP       = 7'h33;
    localparam logic [6:0] OPC_LUI      = 7'h37;
    localparam logic [6:0] OPC_BRANCH   = 7'h63;
    localparam logic [6:0] OPC_JALR     = 7'h67;
    localparam logic [6:0] OPC_JAL      = 7'h6F;

    typedef struct packed {
        logic [1:0]    op_a_sel;
        logic [2:0]    op_b_sel;
        logic [AW-1:0] alu_op;
        logic          mem_req;
        logic          mem_we;
        logic [2:0]    mem_size;
        logic          gpr_we;
        logic          wb_src;
        logic          branch;
        logic          jal;
        logic          jalr;
        logic          illegal;
        logic [31:0]   imm;
        logic [4:0]    rd;
    } dec_t;

    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
    logic [31:0]         instr_mem [DEPTH];
    logic [PW-1:0]       wptr_q, rptr_q;
    logic [LW-1:0]       level_q;
    logic                push, pop;

    logic                out_valid_q;
    logic [PC_WIDTH-1:0] out_pc_q;
    dec_t                out_dec_q;
    dec_t                dec;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    // A full queue refuses a push even when a pop frees a slot in the same cycle.
    assign bus.in_ready_o = (level_q < FULL_LEVEL) && !flush_i && !rst_i;
    assign push           = bus.in_valid_i && bus.in_ready_o;
    assign pop            = (level_q != '0) && (!out_valid_q || bus.out_ready_i);

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wptr_q]    <= bus.in_pc_i;
            instr_mem[wptr_q] <= bus.in_instr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PW'(1);
            if (pop)  rptr_q <= rptr_q + PW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    assign instr  = instr_mem[rptr_q];
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        dec          = '0;
        dec.rd       = instr[11:7];
        dec.op_a_sel = OP_A_RS1;
        dec.op_b_sel = OP_B_IMM_I;
        dec.alu_op   = ALU_ADD;
        dec.imm      = imm_i;
        if (instr[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_LOAD: begin
                    dec.mem_req  = 1'b1;
                    dec.mem_size = funct3;
                    dec.gpr_we   = 1'b1;
                    dec.wb_src   = 1'b1;
                    dec.illegal  = !(funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
                end
                OPC_STORE: begin
                    dec.op_b_sel = OP_B_IMM_S;
                    dec.imm      = imm_s;
                    dec.mem_req  = 1'b1;
                    dec.mem_we   = 1'b1;
                    dec.mem_size = funct3;
                    dec.illegal  = (funct3 > 3'd2);
                end
                OPC_BRANCH: begin
                    dec.op_b_sel = OP_B_RS2;
                    dec.imm      = imm_b;
                    dec.branch   = 1'b1;
                    case (funct3)
                        3'd0:    dec.alu_op = ALU_EQ;
                        3'd1:    dec.alu_op = ALU_NE;
                        3'd4:    dec.alu_op = ALU_LT;
                        3'd5:    dec.alu_op = ALU_GE;
                        3'd6:    dec.alu_op = ALU_LTU;
                        3'd7:    dec.alu_op = ALU_GEU;
                        default: dec.illegal = 1'b1;
                    endcase
                end
                OPC_JAL: begin
                    dec.op_a_sel = OP_A_CURR_PC;
                    dec.op_b_sel = OP_B_INCR;
                    dec.imm      = imm_j;
                    dec.gpr_we   = 1'b1;
                    dec.jal      = 1'b1;
                end
                OPC_JALR: begin
                    dec.op_a_sel = OP_A_CURR_PC;
                    dec.op_b_sel = OP_B_INCR;
                    dec.gpr_we   = 1'b1;
                    dec.jalr     = 1'b1;
                    dec.illegal  = (funct3 != 3'd0);
                end
                OPC_LUI, OPC_AUIPC: begin
                    dec.op_a_sel = (opcode == OPC_LUI) ? OP_A_ZERO : OP_A_CURR_PC;
                    dec.op_b_sel = OP_B_IMM_U;
                    dec.imm      = imm_u;
                    dec.gpr_we   = 1'b1;
                end
                OPC_OP_IMM: begin
                    dec.gpr_we = 1'b1;
                    case (funct3)
                        3'd0: dec.alu_op = ALU_ADD;
                        3'd1: begin
                            dec.alu_op  = ALU_SLL;
                            dec.illegal = (funct7 != 7'h00);
                        end
                        3'd2: dec.alu_op = ALU_SLT;
                        3'd3: dec.alu_op = ALU_SLTU;
                        3'd4: dec.alu_op = ALU_XOR;
                        3'd5: begin
                            dec.alu_op  = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                            dec.illegal = !(funct7 inside {7'h00, 7'h20});
                        end
                        3'd6: dec.alu_op = ALU_OR;
                        default: dec.alu_op = ALU_AND;
                    endcase
                end
                OPC_OP: begin
                    dec.op_b_sel = OP_B_RS2;
                    dec.gpr_we   = 1'b1;
                    case ({funct7, funct3})
                        {7'h00, 3'd0}: dec.alu_op = ALU_ADD;
                        {7'h20, 3'd0}: dec.alu_op = ALU_SUB;
                        {7'h00, 3'd1}: dec.alu_op = ALU_SLL;
                        {7'h00, 3'd2}: dec.alu_op = ALU_SLT;
                        {7'h00, 3'd3}: dec.alu_op = ALU_SLTU;
                        {7'h00, 3'd4}: dec.alu_op = ALU_XOR;
                        {7'h00, 3'd5}: dec.alu_op = ALU_SRL;
                        {7'h20, 3'd5}: dec.alu_op = ALU_SRA;
                        {7'h00, 3'd6}: dec.alu_op = ALU_OR;
                        {7'h00, 3'd7}: dec.alu_op = ALU_AND;
`ifdef DECODE_RV32M_EN
                        {7'h01, 3'd0}: dec.alu_op = ALU_MUL;
                        {7'h01, 3'd1}: dec.alu_op = ALU_MULH;
                        {7'h01, 3'd2}: dec.alu_op = ALU_MULHSU;
                        {7'h01, 3'd3}: dec.alu_op = ALU_MULHU;
                        {7'h01, 3'd4}: dec.alu_op = ALU_DIV;
                        {7'h01, 3'd5}: dec.alu_op = ALU_DIVU;
                        {7'h01, 3'd6}: dec.alu_op = ALU_REM;
                        {7'h01, 3'd7}: dec.alu_op = ALU_REMU;
`endif
                        default: dec.illegal = 1'b1;
                    endcase
                end
                OPC_MISC_MEM: ; // fences have no effect in this pipeline
                default: dec.illegal = 1'b1;
            endcase
        end
        // An undecodable instruction must never request side effects downstream.
        if (dec.illegal) begin
            dec.mem_req = 1'b0;
            dec.mem_we  = 1'b0;
            dec.gpr_we  = 1'b0;
            dec.branch  = 1'b0;
            dec.jal     = 1'b0;
            dec.jalr    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_dec_q   <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_pc_q    <= pc_mem[rptr_q];
            out_dec_q   <= dec;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid_o     = out_valid_q;
    assign bus.out_pc_o        = out_pc_q;
    assign bus.ex_op_a_sel_o   = out_dec_q.op_a_sel;
    assign bus.ex_op_b_sel_o   = out_dec_q.op_b_sel;
    assign bus.alu_op_o        = out_dec_q.alu_op;
    assign bus.mem_req_o       = out_dec_q.mem_req;
    assign bus.mem_we_o        = out_dec_q.mem_we;
    assign bus.mem_size_o      = out_dec_q.mem_size;
    assign bus.gpr_we_a_o      = out_dec_q.gpr_we;
    assign bus.wb_src_sel_o    = out_dec_q.wb_src;
    assign bus.branch_o        = out_dec_q.branch;
    assign bus.jal_o           = out_dec_q.jal;
    assign bus.jalr_o          = out_dec_q.jalr;
    assign bus.illegal_instr_o = out_dec_q.illegal;
    assign bus.imm_o           = out_dec_q.imm;
    assign bus.rd_o            = out_dec_q.rd;
    assign bus.level_o         = level_q;
endmodule

// File: tb/tb_riscv_decode_stage.sv
// Scoreboard bench for riscv_decode_stage: directed cases then randomized traffic with flushes,
// each output bundle checked against an instruction-level RV32I(M) reference model.
module tb_riscv_decode_stage;
    localparam int unsigned DEPTH = 2;

    localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_XOR = 5'd2,  ALU_OR = 5'd3;
    localparam logic [4:0] ALU_AND = 5'd4,  ALU_SLL = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7;
    localparam logic [4:0] ALU_SLT = 5'd8,  ALU_SLTU = 5'd9, ALU_EQ = 5'd10,  ALU_NE = 5'd11;
    localparam logic [4:0] ALU_LT = 5'd12,  ALU_GE = 5'd13,  ALU_LTU = 5'd14, ALU_GEU = 5'd15;
    localparam logic [4:0] ALU_MUL = 5'd16;

    localparam logic [4:0] BASE_ALU [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                            ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    localparam logic [4:0] BR_ALU [8]   = '{ALU_EQ, ALU_NE, 5'd0, 5'd0,
                                            ALU_LT, ALU_GE, ALU_LTU, ALU_GEU};
    localparam logic [6:0] OPCODES [12] = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37,
                                            7'h17, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h5B};

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  a;
        logic [2:0]  b;
        logic [4:0]  alu;
        logic        req, we;
        logic [2:0]  size;
        logic        gwe, wb, br, jal, jalr, ill;
        logic [31:0] imm;
        logic [4:0]  rd;
    } bundle_t;

    typedef struct packed {
        bundle_t    b;
        logic [6:0] opc;
    } exp_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    logic    flush = 1'b0;
    int      n_tests = 0;
    int      n_fail = 0;
    exp_t    exp_q [$];
    bundle_t got;

    riscv_decode_stage_if #(.DEPTH(DEPTH), .PC_WIDTH(32)) bus ();

    riscv_decode_stage #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    assign got = {bus.out_pc_o, bus.ex_op_a_sel_o, bus.ex_op_b_sel_o, bus.alu_op_o,
                  bus.mem_req_o, bus.mem_we_o, bus.mem_size_o, bus.gpr_we_a_o,
                  bus.wb_src_sel_o, bus.branch_o, bus.jal_o, bus.jalr_o,
                  bus.illegal_instr_o, bus.imm_o, bus.rd_o};

    // Reference decode written from the ISA tables: classify by opcode, then legality by set.
    function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc);
        bundle_t     m;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] ii, is, ib, iu, ij;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        ii  = $signed(ins) >>> 20;
        is  = (ii & ~32'h1F) | {27'd0, ins[11:7]};
        ib  = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        iu  = ins & 32'hFFFF_F000;
        ij  = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        m     = '0;
        m.pc  = pc;
        m.rd  = ins[11:7];
        m.ill = 1'b1;
        m.imm = ii;
        m.b   = 3'd1;
        if (ins[1:0] == 2'b11) begin
            case (opc)
                7'h03: if (f3 inside {0, 1, 2, 4, 5}) begin
                    m.ill = 0; m.req = 1; m.size = f3; m.gwe = 1; m.wb = 1;
                end
                7'h23: if (f3 <= 2) begin
                    m.ill = 0; m.req = 1; m.we = 1; m.size = f3; m.b = 3'd3; m.imm = is;
                end
                7'h63: if (!(f3 inside {2, 3})) begin
                    m.ill = 0; m.br = 1; m.b = 3'd0; m.alu = BR_ALU[f3]; m.imm = ib;
                end
                7'h6F: begin
                    m.ill = 0; m.jal = 1; m.gwe = 1; m.a = 2'd1; m.b = 3'd4; m.imm = ij;
                end
                7'h67: if (f3 == 0) begin
                    m.ill = 0; m.jalr = 1; m.gwe = 1; m.a = 2'd1; m.b = 3'd4;
                end
                7'h37, 7'h17: begin
                    m.ill = 0; m.gwe = 1; m.a = (opc == 7'h37) ? 2'd2 : 2'd1;
                    m.b = 3'd2; m.imm = iu;
                end
                7'h13: begin
                    m.ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 inside {0, 7'h20}));
                    m.gwe = !m.ill;
                    m.alu = (f3 == 5 && f7 == 7'h20) ? ALU_SRA : BASE_ALU[f3];
                end
                7'h33: begin
                    m.b = 3'd0;
                    if (f7 == 0) begin
                        m.ill = 0; m.alu = BASE_ALU[f3];
                    end else if (f7 == 7'h20 && f3 inside {0, 5}) begin
                        m.ill = 0; m.alu = (f3 == 0) ? ALU_SUB : ALU_SRA;
                    end
`ifdef DECODE_RV32M_EN
                    else if (f7 == 7'h01) begin
                        m.ill = 0; m.alu = ALU_MUL + 5'(f3);
                    end
`endif
                    m.gwe = !m.ill;
                end
                7'h0F: m.ill = 0;
                default: ;
            endcase
        end
        return m;
    endfunction

    // Zero the fields the decoder is free to choose for this instruction class.
    function automatic bundle_t norm(input bundle_t v, input bundle_t e, input logic [6:0] opc);
        bundle_t r;
        r = v;
        if (e.ill) begin
            r.a = '0; r.b = '0; r.alu = '0; r.size = '0; r.wb = '0; r.imm = '0; r.rd = '0;
        end else begin
            if (!e.req) r.size = '0;
            if (opc == 7'h33 || opc == 7'h0F) r.imm = '0;
            if (opc == 7'h0F) begin
                r.a = '0; r.b = '0; r.alu = '0;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: r[31:25] = 7'h00;
            1: r[31:25] = 7'h20;
            2: r[31:25] = 7'h01;
            default: ;
        endcase
        r[6:0] = OPCODES[$urandom_range(0, 11)];
        if ($urandom_range(0, 15) == 0) r[1:0] = 2'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: sampled mid-cycle, reflecting what the next rising edge will commit.
    initial begin
        bundle_t prev;
        logic    hold;
        exp_t    e;
        hold = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst || flush) begin
                exp_q.delete();
                hold = 1'b0;
            end else begin
                chk("occupancy", 32'(bus.level_o) + 32'(bus.out_valid_o), 32'(exp_q.size()));
                if (hold) begin
                    n_tests++;
                    if (got !== prev) begin
                        n_fail++;
                        $display("FAIL stall_hold: got %h, expected %h", got, prev);
                    end
                end
                if (bus.out_valid_o && bus.out_ready_i) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_output: got %h, expected none", got);
                    end else begin
                        e = exp_q.pop_front();
                        if (norm(got, e.b, e.opc) !== norm(e.b, e.b, e.opc)) begin
                            n_fail++;
                            $display("FAIL bundle: got %h, expected %h", got, e.b);
                        end
                    end
                end
                hold = bus.out_valid_o && !bus.out_ready_i;
                prev = got;
                if (bus.in_valid_i && bus.in_ready_o) begin
                    e.b   = model(bus.in_instr_i, bus.in_pc_i);
                    e.opc = bus.in_instr_i[6:0];
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Present an instruction until accepted; returns 1 ns after the accepting edge.
    task automatic push(input logic [31:0] ins, input logic [31:0] pc);
        logic acc;
        int   n;
        bus.in_valid_i = 1'b1;
        bus.in_instr_i = ins;
        bus.in_pc_i    = pc;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        bus.in_valid_i = 1'b0;
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        bus.out_ready_i = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid_o) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_instr_i  = '0;
        bus.in_pc_i     = '0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_level", 32'(bus.level_o), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        chk("rst_fields_zero", 32'(got != '0), 32'd0);
        rst = 1'b0;
        bus.out_ready_i = 1'b1;

        // add x1,x2,x3: two-edge latency
        push(32'h0031_00B3, 32'h100);
        chk("add_lat_n", 32'(bus.out_valid_o), 32'd0);
        chk("add_level_n", 32'(bus.level_o), 32'd1);
        @(posedge clk); #1;
        chk("add_lat_n1", 32'(bus.out_valid_o), 32'd1);
        chk("add_alu", 32'(bus.alu_op_o), 32'(ALU_ADD));
        chk("add_gpr_we", 32'(bus.gpr_we_a_o), 32'd1);
        chk("add_rd", 32'(bus.rd_o), 32'd1);

        // lw x1,-4(x2)
        push(32'hFFC1_2083, 32'h104);
        @(posedge clk); #1;
        chk("lw_req", 32'(bus.mem_req_o), 32'd1);
        chk("lw_size", 32'(bus.mem_size_o), 32'd2);
        chk("lw_wb", 32'(bus.wb_src_sel_o), 32'd1);
        chk("lw_imm", bus.imm_o, 32'hFFFF_FFFC);

        // ecall, then funct7=0x01 on OP
        push(32'h0000_0073, 32'h108);
        @(posedge clk); #1;
        chk("ecall_illegal", 32'(bus.illegal_instr_o), 32'd1);
        chk("ecall_enables", 32'({bus.mem_req_o, bus.mem_we_o, bus.gpr_we_a_o, bus.branch_o,
                                  bus.jal_o, bus.jalr_o}), 32'd0);
        push(32'h0220_8033, 32'h10C);
        @(posedge clk); #1;
`ifdef DECODE_RV32M_EN
        chk("mul_illegal", 32'(bus.illegal_instr_o), 32'd0);
        chk("mul_alu", 32'(bus.alu_op_o), 32'(ALU_MUL));
`else
        chk("mul_illegal", 32'(bus.illegal_instr_o), 32'd1);
        chk("mul_gpr_we", 32'(bus.gpr_we_a_o), 32'd0);
`endif
        drain();

        // Backpressure: DEPTH+1 fit, the next is refused even with a pop in the same cycle.
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(32'h0000_0013 + (i << 7), 32'h200 + 4 * i);
        bus.in_valid_i = 1'b1;
        bus.in_instr_i = 32'h0FF0_0093;
        @(negedge clk);
        chk("full_level", 32'(bus.level_o), DEPTH);
        chk("full_in_ready", 32'(bus.in_ready_o), 32'd0);
        @(posedge clk); #1;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", 32'(bus.in_ready_o), 32'd0);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        drain();

        // Flush with a simultaneous push: nothing survives, flushed-cycle input is dropped.
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(32'h0000_0113 + (i << 20), 32'h300 + 4 * i);
        flush = 1'b1;
        bus.in_valid_i = 1'b1;
        bus.in_instr_i = 32'h0050_0093;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        chk("flush_level", 32'(bus.level_o), 32'd0);
        chk("flush_valid", 32'(bus.out_valid_o), 32'd0);
        bus.out_ready_i = 1'b1;
        push(32'h0070_0113, 32'h400);
        drain();

        // Reset mid-stream, then normal decode.
        bus.out_ready_i = 1'b0;
        push(32'h0000_0013, 32'h500);
        push(32'h0000_0093, 32'h504);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_fields", 32'(got != '0), 32'd0);
        chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("mid_rst_level", 32'(bus.level_o), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        push(32'hFFC1_2083, 32'h600);
        @(posedge clk); #1;
        chk("post_rst_valid", 32'(bus.out_valid_o), 32'd1);
        chk("post_rst_imm", bus.imm_o, 32'hFFFF_FFFC);
        drain();

        // Randomized traffic with random backpressure and sparse flushes.
        for (int c = 0; c < 1500; c++) begin
            bus.in_valid_i  = ($urandom_range(0, 2) != 0);
            bus.in_instr_i  = rand_instr();
            bus.in_pc_i     = $urandom & ~32'h3;
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            flush           = ($urandom_range(0, 59) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
